// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first unsigned subtractor, one bit per clock.
// Produces a_in - b_in modulo 2^WIDTH plus the final borrow after WIDTH SHIFT cycles.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic             br_q, br_d, bit_d;
    logic [CW-1:0]    cnt_q;

    always_comb begin
        bit_d = a_q[0] ^ b_q[0] ^ br_q;
        br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_d = {bit_d, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            br_q       <= 1'b0;
            cnt_q      <= '0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_out <= 1'b0;
                    if (start_in) begin
                        a_q      <= a_in;
                        b_q      <= b_in;
                        res_q    <= '0;
                        br_q     <= 1'b0;
                        cnt_q    <= '0;
                        busy_out <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + 1'b1;
                    // Last bit: publish the completed result straight from the next-state value
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        busy_out   <= 1'b0;
                        done_out   <= 1'b1;
                        diff_out   <= res_d;
                        borrow_out <= br_d;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    done_out <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    busy_out <= 1'b0;
                    done_out <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end
endmodule
